// File: rtl/uart_block_packer.sv
// Packs the UART byte stream into 128-bit blocks and hands each one to the AES block FIFO.
// Optional inter-byte timeout: define UART_BLOCK_PACKER_BYTE_TIMEOUT_EN.
//
// state     | meaning
// S_COLLECT | accepting bytes into the shift register
// S_WAIT    | block complete, waiting for a free FIFO slot; bytes dropped
// S_WRITE   | one-cycle write strobe to the FIFO; bytes dropped
// S_GAP     | FIFO finishing its write sequence; bytes accepted again
module uart_block_packer #(
    parameter int WR_GAP         = 3,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    input  logic         fifo_overflow,
    output logic [127:0] fifo_d_in,
    output logic         fifo_write_en,
    output logic [3:0]   byte_cnt,
    output logic         busy,
    output logic         drop_err,
    output logic [7:0]   drop_cnt,
    output logic         timeout_err
);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_WAIT    = 2'd1,
        S_WRITE   = 2'd2,
        S_GAP     = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   shreg_q, shreg_d;
    logic [127:0]   fifo_d_in_q, fifo_d_in_d;
    logic           write_en_q, write_en_d;
    logic [3:0]     byte_cnt_q, byte_cnt_d;
    logic [3:0]     gap_q, gap_d;
    logic           drop_err_q, drop_err_d;
    logic [7:0]     drop_cnt_q, drop_cnt_d;
    logic           collecting;

`ifdef UART_BLOCK_PACKER_BYTE_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(TIMEOUT_CYCLES);
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              timeout_err_q, timeout_err_d;
`endif

    assign collecting = (state_q == S_COLLECT) || (state_q == S_GAP);

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        fifo_d_in_d = fifo_d_in_q;
        write_en_d  = 1'b0;
        byte_cnt_d  = byte_cnt_q;
        gap_d       = gap_q;
        drop_err_d  = 1'b0;
        drop_cnt_d  = drop_cnt_q;
`ifdef UART_BLOCK_PACKER_BYTE_TIMEOUT_EN
        idle_d        = IDLE_LOAD;
        timeout_err_d = 1'b0;
`endif

        if (rx_valid) begin
            if (collecting) begin
                shreg_d    = {shreg_q[119:0], rx_data};
                byte_cnt_d = byte_cnt_q + 4'd1;
            end else begin
                drop_err_d = 1'b1;
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
        end

        case (state_q)
            S_COLLECT: begin
                if (rx_valid && (byte_cnt_q == 4'd15)) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!fifo_overflow) begin
                    fifo_d_in_d = shreg_q;
                    write_en_d  = 1'b1;
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                gap_d   = 4'(WR_GAP - 1);
                state_d = S_GAP;
            end
            S_GAP: begin
                // Unreachable while WR_GAP < 16, kept so a full block is never lost.
                if (rx_valid && (byte_cnt_q == 4'd15)) begin
                    state_d = S_WAIT;
                end else if (gap_q == 4'd0) begin
                    state_d = S_COLLECT;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = S_COLLECT;
        endcase

`ifdef UART_BLOCK_PACKER_BYTE_TIMEOUT_EN
        // Idle down-counter restarts on every accepted byte and whenever no partial block exists.
        if (collecting && (byte_cnt_q != 4'd0) && !rx_valid) begin
            if (idle_q == IDLE_W'(1)) begin
                byte_cnt_d    = 4'd0;
                shreg_d       = '0;
                timeout_err_d = 1'b1;
            end else begin
                idle_d = idle_q - IDLE_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_COLLECT;
            shreg_q     <= '0;
            fifo_d_in_q <= '0;
            write_en_q  <= 1'b0;
            byte_cnt_q  <= 4'd0;
            gap_q       <= 4'd0;
            drop_err_q  <= 1'b0;
            drop_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            fifo_d_in_q <= fifo_d_in_d;
            write_en_q  <= write_en_d;
            byte_cnt_q  <= byte_cnt_d;
            gap_q       <= gap_d;
            drop_err_q  <= drop_err_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

`ifdef UART_BLOCK_PACKER_BYTE_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_q        <= IDLE_LOAD;
            timeout_err_q <= 1'b0;
        end else begin
            idle_q        <= idle_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign fifo_d_in     = fifo_d_in_q;
    assign fifo_write_en = write_en_q;
    assign byte_cnt      = byte_cnt_q;
    assign busy          = (state_q == S_WAIT) || (state_q == S_WRITE);
    assign drop_err      = drop_err_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_uart_block_packer.sv
// Directed bench for uart_block_packer: expected blocks are queued when bytes are sent
// and compared when the write strobe appears.
module tb_uart_block_packer;

    localparam int WR_GAP = 3;

    logic         clk;
    logic         reset;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         fifo_overflow;
    logic [127:0] fifo_d_in;
    logic         fifo_write_en;
    logic [3:0]   byte_cnt;
    logic         busy;
    logic         drop_err;
    logic [7:0]   drop_cnt;
    logic         timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_count = 0;
    logic prev_we = 1'b0;
    logic [127:0] exp_q[$];
    int wr_cyc_q[$];

    uart_block_packer #(.WR_GAP(WR_GAP), .TIMEOUT_CYCLES(50)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .fifo_overflow (fifo_overflow),
        .fifo_d_in     (fifo_d_in),
        .fifo_write_en (fifo_write_en),
        .byte_cnt      (byte_cnt),
        .busy          (busy),
        .drop_err      (drop_err),
        .drop_cnt      (drop_cnt),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Scoreboard side: every strobe must be a single cycle and match the oldest queued block.
    always @(negedge clk) begin
        if (fifo_write_en === 1'b1) begin
            wr_count = wr_count + 1;
            wr_cyc_q.push_back(cyc);
            check("we_single_cycle", 128'(prev_we), 128'd0);
            check("write_expected", 128'(exp_q.size() > 0), 128'd1);
            if (exp_q.size() > 0) check("block_data", fifo_d_in, exp_q.pop_front());
        end
        prev_we = fifo_write_en;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; fifo_overflow = 1'b0;
        #12;
        check("rst_we", 128'(fifo_write_en), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_byte_cnt", 128'(byte_cnt), 128'd0);
        check("rst_drop_cnt", 128'(drop_cnt), 128'd0);
        check("rst_drop_err", 128'(drop_err), 128'd0);
        check("rst_d_in", fifo_d_in, 128'd0);
        check("rst_timeout", 128'(timeout_err), 128'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        tick(2);

        // Slow stream, one byte every 10 cycles
        exp_q.push_back(128'h000102030405060708090A0B0C0D0E0F);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i));
            if (i == 7) check("t1_byte_cnt8", 128'(byte_cnt), 128'd8);
            if (i < 15) tick(9);
        end
        check("t1_we_k", 128'(fifo_write_en), 128'd0);
        check("t1_busy_wait", 128'(busy), 128'd1);
        check("t1_byte_cnt_wrap", 128'(byte_cnt), 128'd0);
        tick(1);
        check("t1_we_k1", 128'(fifo_write_en), 128'd1);
        check("t1_d_in", fifo_d_in, 128'h000102030405060708090A0B0C0D0E0F);
        check("t1_busy_write", 128'(busy), 128'd1);
        tick(1);
        check("t1_we_k2", 128'(fifo_write_en), 128'd0);
        check("t1_busy_gap", 128'(busy), 128'd0);
        tick(10);
        check("t1_wr_count", 128'(wr_count), 128'd1);

        // Overflow held when the block completes, three bytes dropped
        exp_q.push_back(128'h101112131415161718191A1B1C1D1E1F);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) fifo_overflow = 1'b1;
            send_byte(8'(8'h10 + i));
        end
        check("t2_busy", 128'(busy), 128'd1);
        tick(3);
        check("t2_busy_held", 128'(busy), 128'd1);
        check("t2_no_we", 128'(fifo_write_en), 128'd0);
        for (int j = 0; j < 3; j++) begin
            send_byte(8'hEE);
            check("t2_drop_err_hi", 128'(drop_err), 128'd1);
            tick(1);
            check("t2_drop_err_lo", 128'(drop_err), 128'd0);
        end
        check("t2_drop_cnt", 128'(drop_cnt), 128'd3);
        check("t2_byte_cnt", 128'(byte_cnt), 128'd0);
        check("t2_wr_count", 128'(wr_count), 128'd1);
        fifo_overflow = 1'b0;
        tick(1);
        check("t2_we", 128'(fifo_write_en), 128'd1);
        check("t2_d_in", fifo_d_in, 128'h101112131415161718191A1B1C1D1E1F);
        tick(1);
        check("t2_we_off", 128'(fifo_write_en), 128'd0);
        tick(6);

        // Back-to-back blocks with a byte every cycle
        exp_q.push_back(128'h202122232425262728292A2B2C2D2E2F);
        exp_q.push_back(128'h32333435363738393A3B3C3D3E3F4041);
        for (int i = 0; i < 34; i++) begin
            send_byte(8'(8'h20 + i));
            if (i == 15) check("t3_busy_wait", 128'(busy), 128'd1);
            if (i == 16) check("t3_we", 128'(fifo_write_en), 128'd1);
            if (i >= 17 && i <= 20) check("t3_d_in_hold", fifo_d_in, 128'h202122232425262728292A2B2C2D2E2F);
            if (i == 18) check("t3_gap_accept", 128'(byte_cnt), 128'd1);
        end
        tick(1);
        check("t3_we2", 128'(fifo_write_en), 128'd1);
        check("t3_d_in2", fifo_d_in, 128'h32333435363738393A3B3C3D3E3F4041);
        tick(6);
        check("t3_drop_cnt", 128'(drop_cnt), 128'd5);
        d = wr_cyc_q[wr_cyc_q.size()-1] - wr_cyc_q[wr_cyc_q.size()-2];
        check("t3_wr_spacing", 128'(d >= WR_GAP + 1), 128'd1);

        // Asynchronous reset mid-block and during the write strobe
        for (int i = 0; i < 8; i++) send_byte(8'(8'h60 + i));
        check("t4_byte_cnt8", 128'(byte_cnt), 128'd8);
        #2 reset = 1'b0;
        #1;
        check("t4_rst_byte_cnt", 128'(byte_cnt), 128'd0);
        check("t4_rst_d_in", fifo_d_in, 128'd0);
        check("t4_rst_drop_cnt", 128'(drop_cnt), 128'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        tick(1);
        for (int i = 0; i < 16; i++) send_byte(8'(8'h70 + i));
        tick(1);
        check("t4_we_before_rst", 128'(fifo_write_en), 128'd1);
        #1 reset = 1'b0;
        #1;
        check("t4_rst_we", 128'(fifo_write_en), 128'd0);
        check("t4_rst_busy", 128'(busy), 128'd0);
        check("t4_rst_d_in2", fifo_d_in, 128'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        tick(1);
        exp_q.push_back(128'h505152535455565758595A5B5C5D5E5F);
        for (int i = 0; i < 16; i++) send_byte(8'(8'h50 + i));
        tick(1);
        check("t4_clean_we", 128'(fifo_write_en), 128'd1);
        check("t4_clean_d_in", fifo_d_in, 128'h505152535455565758595A5B5C5D5E5F);
        tick(6);

        // drop_cnt saturation
        fifo_overflow = 1'b1;
        exp_q.push_back(128'h808182838485868788898A8B8C8D8E8F);
        for (int i = 0; i < 16; i++) send_byte(8'(8'h80 + i));
        for (int n = 1; n <= 300; n++) begin
            send_byte(8'hCC);
            if (n == 254) check("t5_drop_254", 128'(drop_cnt), 128'd254);
            if (n == 255) check("t5_drop_255", 128'(drop_cnt), 128'd255);
        end
        check("t5_drop_sat", 128'(drop_cnt), 128'd255);
        check("t5_drop_err", 128'(drop_err), 128'd1);
        check("t5_byte_cnt", 128'(byte_cnt), 128'd0);
        fifo_overflow = 1'b0;
        tick(1);
        check("t5_we", 128'(fifo_write_en), 128'd1);
        tick(6);

`ifdef UART_BLOCK_PACKER_BYTE_TIMEOUT_EN
        for (int i = 0; i < 5; i++) send_byte(8'(8'h90 + i));
        tick(49);
        check("t6_no_timeout_yet", 128'(timeout_err), 128'd0);
        check("t6_byte_cnt5", 128'(byte_cnt), 128'd5);
        tick(1);
        check("t6_timeout", 128'(timeout_err), 128'd1);
        check("t6_byte_cnt0", 128'(byte_cnt), 128'd0);
        tick(1);
        check("t6_timeout_pulse", 128'(timeout_err), 128'd0);
        exp_q.push_back(128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        for (int i = 0; i < 16; i++) send_byte(8'(8'hA0 + i));
        tick(1);
        check("t6_we", 128'(fifo_write_en), 128'd1);
        check("t6_d_in", fifo_d_in, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        tick(6);
        check("final_wr_count", 128'(wr_count), 128'd7);
`else
        check("final_wr_count", 128'(wr_count), 128'd6);
`endif
        check("final_queue_drained", 128'(exp_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
